// File: rtl/darkedram_pkg.sv
// Shared types and constants for the darkedram data-memory arbiter.
//   arb_state_t : sequencer state (IDLE, BUSY, RESP)
//   req_idx_t   : requester index (0 = core data port, 1 = DMA/debug port)
//   ERR_DATA_DEFAULT : read data returned when the slave times out
//   cnt_width() : width of the timeout counter for a given TIMEOUT
package darkedram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Counter must hold values up to TIMEOUT-1; a zero TIMEOUT still needs one bit.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/darkedram_rr_pick.sv
// Combinational 2-way round-robin pick.
//   req  : request vector {req1, req0}
//   last : index granted last time
//   vld  : at least one request present
//   idx  : chosen requester (meaningful only while vld)
module darkedram_rr_pick
  import darkedram_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  output logic       vld,
  output req_idx_t   idx
);

  assign vld = |req;
  // On a conflict the requester that did not win last time goes next.
  assign idx = (&req) ? ~last : req[1];

endmodule

// File: rtl/darkedram_arb.sv
// Two-requester arbiter and sequencer for the darkedram data-memory slave.
//   XCLK, XRES           : clock, asynchronous active-low reset
//   M0_* / M1_*          : requester ports (REQ/WE/ADDR/WDATA/BE in,
//                          RDATA/ACK/ERR out); M0 = core, M1 = DMA/debug
//   S_*                  : registered command to the slave, RDATA/RACK/WACK back
//   BUSY                 : sequencer not idle
//   GNT                  : index of the last granted requester
// A transaction is IDLE (arbitrate) -> BUSY (wait for ack or timeout) ->
// RESP (one-cycle ACK), so back-to-back transactions take three cycles.
module darkedram_arb
  import darkedram_pkg::arb_state_t, darkedram_pkg::req_idx_t,
         darkedram_pkg::ERR_DATA_DEFAULT, darkedram_pkg::cnt_width;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  input  logic [3:0]  M0_BE,
  output logic [31:0] M0_RDATA,
  output logic        M0_ACK,
  output logic        M0_ERR,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  input  logic [3:0]  M1_BE,
  output logic [31:0] M1_RDATA,
  output logic        M1_ACK,
  output logic        M1_ERR,
  output logic        S_EN,
  output logic        S_WE,
  output logic        S_RE,
  output logic [31:0] S_ADDR,
  output logic [31:0] S_WDATA,
  output logic [3:0]  S_BE,
  input  logic [31:0] S_RDATA,
  input  logic        S_RACK,
  input  logic        S_WACK,
  output logic        BUSY,
  output logic        GNT
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_t    state;
  req_idx_t      gnt;
  logic [CW-1:0] cnt;
  logic [1:0]    ack;
  logic [1:0]    err;
  logic [31:0]   rdata0;
  logic [31:0]   rdata1;

  logic          pick_vld;
  req_idx_t      pick_idx;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;
  logic          ack_hit;
  logic          to_hit;
  logic [31:0]   resp_data;

  darkedram_rr_pick u_pick (
    .req  ({M1_REQ, M0_REQ}),
    .last (gnt),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  assign sel_we    = pick_idx ? M1_WE    : M0_WE;
  assign sel_addr  = pick_idx ? M1_ADDR  : M0_ADDR;
  assign sel_wdata = pick_idx ? M1_WDATA : M0_WDATA;
  assign sel_be    = pick_idx ? M1_BE    : M0_BE;

  assign ack_hit = (S_RE & S_RACK) | (S_WE & S_WACK);
  // An ack on the last allowed cycle takes priority over the timeout.
  assign to_hit  = (TIMEOUT != 0) && (cnt == CNT_LAST) && !ack_hit;

  // Writes always return zero; a timed-out read returns the error pattern.
  assign resp_data = !S_RE   ? 32'h0 :
                     ack_hit ? S_RDATA : ERR_DATA;

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state   <= darkedram_pkg::IDLE;
      gnt     <= 1'b1;
      cnt     <= '0;
      S_EN    <= 1'b0;
      S_WE    <= 1'b0;
      S_RE    <= 1'b0;
      S_ADDR  <= '0;
      S_WDATA <= '0;
      S_BE    <= '0;
      ack     <= '0;
      err     <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      case (state)
        darkedram_pkg::IDLE: begin
          if (pick_vld) begin
            gnt     <= pick_idx;
            cnt     <= '0;
            S_EN    <= 1'b1;
            S_WE    <= sel_we;
            S_RE    <= !sel_we;
            S_ADDR  <= sel_addr;
            S_WDATA <= sel_wdata;
            S_BE    <= sel_be;
            state   <= darkedram_pkg::BUSY;
          end
        end
        darkedram_pkg::BUSY: begin
          if (ack_hit || to_hit) begin
            S_EN     <= 1'b0;
            S_WE     <= 1'b0;
            S_RE     <= 1'b0;
            ack[gnt] <= 1'b1;
            err[gnt] <= to_hit;
            if (gnt) rdata1 <= resp_data;
            else     rdata0 <= resp_data;
            state    <= darkedram_pkg::RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        darkedram_pkg::RESP: begin
          ack    <= '0;
          err    <= '0;
          rdata0 <= '0;
          rdata1 <= '0;
          state  <= darkedram_pkg::IDLE;
        end
        default: state <= darkedram_pkg::IDLE;
      endcase
    end
  end

  assign M0_ACK   = ack[0];
  assign M1_ACK   = ack[1];
  assign M0_ERR   = err[0];
  assign M1_ERR   = err[1];
  assign M0_RDATA = rdata0;
  assign M1_RDATA = rdata1;
  assign BUSY     = (state != darkedram_pkg::IDLE);
  assign GNT      = gnt;

endmodule

// File: tb/tb_darkedram_arb.sv
// Directed, table-driven bench for darkedram_arb (TIMEOUT=16).
module tb_darkedram_arb;

  logic        XCLK = 1'b0;
  logic        XRES = 1'b0;
  logic        M0_REQ = 1'b0, M0_WE = 1'b0;
  logic [31:0] M0_ADDR = '0, M0_WDATA = '0;
  logic [3:0]  M0_BE = '0;
  logic [31:0] M0_RDATA;
  logic        M0_ACK, M0_ERR;
  logic        M1_REQ = 1'b0, M1_WE = 1'b0;
  logic [31:0] M1_ADDR = '0, M1_WDATA = '0;
  logic [3:0]  M1_BE = '0;
  logic [31:0] M1_RDATA;
  logic        M1_ACK, M1_ERR;
  logic        S_EN, S_WE, S_RE;
  logic [31:0] S_ADDR, S_WDATA;
  logic [3:0]  S_BE;
  logic [31:0] S_RDATA = '0;
  logic        S_RACK = 1'b0, S_WACK = 1'b0;
  logic        BUSY, GNT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 XCLK = ~XCLK;

  darkedram_arb #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .XCLK(XCLK), .XRES(XRES),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_BE(M0_BE), .M0_RDATA(M0_RDATA), .M0_ACK(M0_ACK), .M0_ERR(M0_ERR),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_BE(M1_BE), .M1_RDATA(M1_RDATA), .M1_ACK(M1_ACK), .M1_ERR(M1_ERR),
    .S_EN(S_EN), .S_WE(S_WE), .S_RE(S_RE), .S_ADDR(S_ADDR), .S_WDATA(S_WDATA),
    .S_BE(S_BE), .S_RDATA(S_RDATA), .S_RACK(S_RACK), .S_WACK(S_WACK),
    .BUSY(BUSY), .GNT(GNT)
  );

  // One transaction: requester inputs, slave behaviour (wt = BUSY cycle index
  // at which the slave acks, 255 = never) and the expected result.
  typedef struct {
    logic [1:0]  req;
    logic        we;
    logic [31:0] a0, a1, wd;
    logic [3:0]  be;
    logic [31:0] sd;
    int          wt;
    int          idx;
    logic [31:0] rd;
    logic        err;
    int          busy;
  } vec_t;

  localparam int NV = 16;
  vec_t vt[NV];

  function automatic vec_t mk(input logic [1:0] req, input logic we,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic [31:0] sd, input int wt, input int idx,
                              input logic [31:0] rd, input logic err, input int busy);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.wd = wd; v.be = be;
    v.sd = sd; v.wt = wt; v.idx = idx; v.rd = rd; v.err = err; v.busy = busy;
    return v;
  endfunction

  function automatic logic [31:0] swap16(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // M0 gets wd / ~be, M1 gets swapped wd / be so the winner is visible on S_*.
  task automatic set_in(input vec_t v);
    M0_REQ = v.req[0];  M1_REQ = v.req[1];
    M0_WE = v.we;       M1_WE = v.we;
    M0_ADDR = v.a0;     M1_ADDR = v.a1;
    M0_WDATA = v.wd;    M1_WDATA = swap16(v.wd);
    M0_BE = ~v.be;      M1_BE = v.be;
    S_RDATA = v.sd;
  endtask

  task automatic clr_in();
    M0_REQ = 1'b0; M1_REQ = 1'b0;
  endtask

  // Entered #1 into an IDLE cycle with the vector already applied.
  task automatic run_vec(input int i);
    vec_t v;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    int bcnt;
    bit done, stable;
    v = vt[i];
    e_addr = (v.idx == 1) ? v.a1 : v.a0;
    e_wd   = (v.idx == 1) ? swap16(v.wd) : v.wd;
    e_be   = (v.idx == 1) ? v.be : ~v.be;
    @(posedge XCLK); #1;
    chk($sformatf("v%0d gnt", i), 32'(GNT), 32'(v.idx));
    chk($sformatf("v%0d s_en", i), 32'(S_EN), 32'd1);
    chk($sformatf("v%0d s_we_re", i), {30'd0, S_WE, S_RE}, {30'd0, v.we, !v.we});
    chk($sformatf("v%0d s_addr", i), S_ADDR, e_addr);
    chk($sformatf("v%0d s_wdata", i), S_WDATA, e_wd);
    chk($sformatf("v%0d s_be", i), 32'(S_BE), 32'(e_be));
    bcnt = 0; done = 0; stable = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      stable &= S_EN && (S_ADDR == e_addr) && (S_WDATA == e_wd) && (S_BE == e_be)
                && (S_WE == v.we) && (S_RE == !v.we);
      S_RACK = S_RE && (bcnt == v.wt);
      S_WACK = S_WE && (bcnt == v.wt);
      @(posedge XCLK); #1;
      S_RACK = 1'b0; S_WACK = 1'b0;
      if (M0_ACK || M1_ACK) done = 1;
      else bcnt++;
    end
    if (!done) begin
      chk($sformatf("v%0d ack_timeout", i), 32'd0, 32'd1);
    end else begin
      chk($sformatf("v%0d stable", i), 32'(stable), 32'd1);
      chk($sformatf("v%0d busy_cycles", i), 32'(bcnt + 1), 32'(v.busy));
      chk($sformatf("v%0d acks", i), {30'd0, M1_ACK, M0_ACK}, 32'(1 << v.idx));
      chk($sformatf("v%0d errs", i), {30'd0, M1_ERR, M0_ERR}, 32'(v.err) << v.idx);
      chk($sformatf("v%0d rdata", i), (v.idx == 1) ? M1_RDATA : M0_RDATA, v.rd);
      chk($sformatf("v%0d other_rdata", i), (v.idx == 1) ? M0_RDATA : M1_RDATA, 32'd0);
      chk($sformatf("v%0d strobes_off", i), {29'd0, S_EN, S_WE, S_RE}, 32'd0);
    end
    if (i + 1 < NV) set_in(vt[i + 1]);
    else clr_in();
    @(posedge XCLK); #1;
    chk($sformatf("v%0d idle_acks", i), {30'd0, M1_ACK, M0_ACK}, 32'd0);
    chk($sformatf("v%0d idle_busy", i), 32'(BUSY), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge XCLK);
    #1;
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst gnt", 32'(GNT), 32'd1);
    chk("rst strobes", {29'd0, S_EN, S_WE, S_RE}, 32'd0);
    chk("rst s_addr", S_ADDR, 32'd0);
    chk("rst acks_errs", {28'd0, M1_ACK, M0_ACK, M1_ERR, M0_ERR}, 32'd0);
    chk("rst rdata", M0_RDATA | M1_RDATA, 32'd0);

    //        req    we    a0        a1        wd            be       sd            wt   idx rd            err busy
    vt[0]  = mk(2'b01, 1'b0, 32'h40,  32'h0,   32'h0,        4'hF,    32'h12345678, 0,   0, 32'h12345678, 0, 1);
    vt[1]  = mk(2'b10, 1'b1, 32'h0,   32'h44,  32'hCCDDAABB, 4'b0010, 32'h99999999, 0,   1, 32'h0,        0, 1);
    vt[2]  = mk(2'b11, 1'b0, 32'h100, 32'h200, 32'h0,        4'h0,    32'h11110000, 0,   0, 32'h11110000, 0, 1);
    vt[3]  = mk(2'b11, 1'b0, 32'h104, 32'h204, 32'h0,        4'h0,    32'h22221111, 1,   1, 32'h22221111, 0, 2);
    vt[4]  = mk(2'b11, 1'b1, 32'h108, 32'h208, 32'h01020304, 4'hF,    32'h33332222, 0,   0, 32'h0,        0, 1);
    vt[5]  = mk(2'b11, 1'b1, 32'h10C, 32'h20C, 32'h05060708, 4'h0,    32'h44443333, 2,   1, 32'h0,        0, 3);
    vt[6]  = mk(2'b11, 1'b0, 32'h110, 32'h210, 32'h0,        4'h0,    32'h55554444, 0,   0, 32'h55554444, 0, 1);
    vt[7]  = mk(2'b11, 1'b0, 32'h114, 32'h214, 32'h0,        4'h0,    32'h66665555, 0,   1, 32'h66665555, 0, 1);
    vt[8]  = mk(2'b11, 1'b0, 32'h118, 32'h218, 32'h0,        4'h0,    32'h77776666, 3,   0, 32'h77776666, 0, 4);
    vt[9]  = mk(2'b11, 1'b1, 32'h11C, 32'h21C, 32'h0A0B0C0D, 4'b1001, 32'h88887777, 0,   1, 32'h0,        0, 1);
    vt[10] = mk(2'b01, 1'b0, 32'h300, 32'h0,   32'h0,        4'h0,    32'hCAFEF00D, 5,   0, 32'hCAFEF00D, 0, 6);
    vt[11] = mk(2'b10, 1'b0, 32'h0,   32'h400, 32'h0,        4'h0,    32'h12121212, 255, 1, 32'hDEADBEEF, 1, 16);
    vt[12] = mk(2'b01, 1'b0, 32'h80,  32'h0,   32'h0,        4'h0,    32'h55AA55AA, 0,   0, 32'h55AA55AA, 0, 1);
    vt[13] = mk(2'b01, 1'b1, 32'h500, 32'h0,   32'h13579BDF, 4'hF,    32'h24682468, 255, 0, 32'h0,        1, 16);
    vt[14] = mk(2'b10, 1'b1, 32'h0,   32'h504, 32'h11223344, 4'h3,    32'h0,        2,   1, 32'h0,        0, 3);
    vt[15] = mk(2'b01, 1'b0, 32'h600, 32'h0,   32'h0,        4'h0,    32'h0F0F0F0F, 15,  0, 32'h0F0F0F0F, 0, 16);

    XRES = 1'b1;
    set_in(vt[0]);
    for (int i = 0; i < NV; i++) run_vec(i);

    // REQ dropped before ACK: the latched write still completes.
    M1_REQ = 1'b1; M1_WE = 1'b1; M1_ADDR = 32'h700; M1_WDATA = 32'h0BADF00D; M1_BE = 4'hF;
    @(posedge XCLK); #1;
    chk("drop s_addr", S_ADDR, 32'h700);
    M1_REQ = 1'b0;
    @(posedge XCLK); #1;
    S_WACK = 1'b1;
    @(posedge XCLK); #1;
    S_WACK = 1'b0;
    chk("drop acks", {30'd0, M1_ACK, M0_ACK}, 32'd2);
    chk("drop err", 32'(M1_ERR), 32'd0);
    @(posedge XCLK); #1;
    chk("drop idle", 32'(BUSY), 32'd0);

    // Reset asserted in the third BUSY cycle.
    M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDR = 32'h800; S_RDATA = 32'hFEEDFACE;
    repeat (3) @(posedge XCLK);
    #2;
    XRES = 1'b0;
    #1;
    chk("rstmid s_en", {29'd0, S_EN, S_WE, S_RE}, 32'd0);
    chk("rstmid busy", 32'(BUSY), 32'd0);
    chk("rstmid gnt", 32'(GNT), 32'd1);
    @(posedge XCLK); #1;
    chk("rstmid no_ack", {30'd0, M1_ACK, M0_ACK}, 32'd0);
    M1_REQ = 1'b1; M1_WE = 1'b0; M1_ADDR = 32'h900;
    XRES = 1'b1;
    @(posedge XCLK); #1;
    chk("rstrel gnt", 32'(GNT), 32'd0);
    chk("rstrel s_addr", S_ADDR, 32'h800);
    chk("rstrel no_ack", {30'd0, M1_ACK, M0_ACK}, 32'd0);
    S_RACK = 1'b1;
    @(posedge XCLK); #1;
    S_RACK = 1'b0;
    M0_REQ = 1'b0; M1_REQ = 1'b0;
    chk("rstrel acks", {30'd0, M1_ACK, M0_ACK}, 32'd1);
    chk("rstrel rdata", M0_RDATA, 32'hFEEDFACE);
    @(posedge XCLK); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/darkedram_arb.md
Name: darkedram_arb

Overview:
- Two-requester arbiter and sequencer in front of the darkedram data-memory slave port.
- Requester 0 is the core data port; requester 1 is the DMA/debug port.
- Grants one requester at a time with round-robin fairness, registers the command onto the slave bus, and waits for RACK/WACK.
- Returns read data and a single-cycle ACK to the granted requester; a stalled slave is aborted with ERR after a timeout.

Parameters:
- TIMEOUT, 16, cycles to wait in BUSY for slave ack before abort; 0 disables the timeout.
- ERR_DATA, 32'hDEADBEEF, RDATA value returned on a timed-out read.

Ports:
- XCLK  in  1  clock
- XRES  in  1  asynchronous active-low reset
- M0_REQ, M1_REQ  in  1  request, held until ACK
- M0_WE, M1_WE  in  1  1=write, 0=read
- M0_ADDR, M1_ADDR  in  32  byte address
- M0_WDATA, M1_WDATA  in  32  write data
- M0_BE, M1_BE  in  4  byte enables
- M0_RDATA, M1_RDATA  out  32  read data, valid while ACK
- M0_ACK, M1_ACK  out  1  single-cycle completion pulse
- M0_ERR, M1_ERR  out  1  qualifies ACK: transaction timed out
- S_EN, S_WE, S_RE  out  1  slave strobes
- S_ADDR  out  32  slave address
- S_WDATA  out  32  slave write data
- S_BE  out  4  slave byte enables
- S_RDATA  in  32  slave read data
- S_RACK, S_WACK  in  1  slave acks
- BUSY  out  1  state != IDLE
- GNT  out  1  index of the last granted requester

Behaviour:
- Reset (XRES=0, asynchronous):
  - state=IDLE.
  - All S_* outputs, ACK, ERR and RDATA = 0.
  - GNT=1, so M0 wins the first conflict.
  - Timeout counter = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both request: grant !GNT.
  - On grant, register the winner's WE/ADDR/WDATA/BE into S_* and set S_EN=1, S_WE=WE, S_RE=!WE. Update GNT and clear the counter. Go to BUSY.
- BUSY:
  - S_* are held stable.
  - Ack condition: (S_RE & S_RACK) | (S_WE & S_WACK).
  - On ack: capture S_RDATA into the winner's RDATA (reads only; writes return 0). Drop S_EN/S_WE/S_RE. Go to RESP with ERR=0.
  - Otherwise the counter increments. When counter==TIMEOUT-1 (TIMEOUT!=0) with no ack: drop the strobes, RDATA=ERR_DATA on a read (0 on a write), ERR=1, go to RESP.
  - An ack arriving on the timeout cycle wins (normal completion).
- RESP:
  - ACK=1 for exactly one cycle to the winner only; ERR as set in BUSY.
  - Next state is IDLE unconditionally.
  - The requester drops REQ, or presents a new command, on the edge that samples ACK.
  - IDLE re-arbitrates on the following cycle, so a request still held after ACK is treated as new.
- Latency: a request seen at edge 0 gives S_EN in cycle 1. With a zero-wait slave, ACK is visible in cycle 2. Peak throughput is one transaction per 3 cycles.
- Fairness: with both REQ held continuously, grants alternate 0,1,0,1.
- A requester dropping REQ before ACK is a protocol violation. The arbiter still completes the latched transaction and pulses ACK.
- BE=0 on a write is passed through unchanged; the slave treats it as a full-word write.
- The non-granted requester's RDATA, ACK and ERR stay 0.
- Reset asserted mid-BUSY:
  - Strobes drop immediately (asynchronous).
  - No ACK is issued.
  - After release the arbiter starts in IDLE.

Decomposition:
- darkedram_pkg:
  - arb_state_t enum {IDLE,BUSY,RESP}.
  - req_idx_t (1 bit).
  - ERR_DATA default constant.
  - Function to compute counter width: $clog2(TIMEOUT+1), minimum 1.
- Sub-module darkedram_rr_pick: combinational 2-way round-robin pick from (REQ[1:0], last) to (valid, idx). It is reused by the future 4-port arbiter.

Test Plan:
- Single read: M0_REQ=1, WE=0, ADDR=0x40, zero-wait slave returning 0x12345678 -> S_EN/S_RE in cycle 1 with S_ADDR=0x40; M0_ACK=1 and M0_RDATA=0x12345678 in cycle 2; M1_ACK stays 0.
- Byte write: M1 writes ADDR=0x44, WDATA=0xAABBCCDD, BE=4'b0010 -> S_WE=1, S_BE=0010, S_WDATA=0xAABBCCDD for one cycle; M1_ACK pulse; M1_RDATA=0.
- Contention: both REQ held 8 transactions from reset -> grant order 0,1,0,1,0,1,0,1; GNT toggles each grant; never two ACKs in the same cycle.
- Wait states: slave delays RACK by 5 cycles -> S_* stable for 6 BUSY cycles; ACK exactly one cycle after RACK; no ERR.
- Timeout: TIMEOUT=16, slave never acks a read -> after 16 BUSY cycles ACK=1, ERR=1, RDATA=0xDEADBEEF; the next request is served normally.
- Reset mid-op: drop XRES in the 3rd BUSY cycle -> S_EN=0 asynchronously; no ACK; after release M0 wins a simultaneous request.
